// File: rtl/release_axi_writer_if.sv
// Bundles the release-queue dequeue side, the AXI4 AW/W/B channels, the grant channel and
// the sticky error flag for release_axi_writer.
interface release_axi_writer_if;
  logic        io_rel_ready;
  logic        io_rel_valid;
  logic [1:0]  io_rel_bits_header_src;
  logic [1:0]  io_rel_bits_header_dst;
  logic [2:0]  io_rel_bits_payload_addr_beat;
  logic [25:0] io_rel_bits_payload_addr_block;
  logic        io_rel_bits_payload_client_xact_id;
  logic        io_rel_bits_payload_voluntary;
  logic [2:0]  io_rel_bits_payload_r_type;
  logic [63:0] io_rel_bits_payload_data;

  logic        io_aw_ready;
  logic        io_aw_valid;
  logic [31:0] io_aw_bits_addr;
  logic [2:0]  io_aw_bits_id;
  logic [7:0]  io_aw_bits_len;
  logic [2:0]  io_aw_bits_size;
  logic [1:0]  io_aw_bits_burst;

  logic        io_w_ready;
  logic        io_w_valid;
  logic [63:0] io_w_bits_data;
  logic [7:0]  io_w_bits_strb;
  logic        io_w_bits_last;

  logic        io_b_ready;
  logic        io_b_valid;
  logic [2:0]  io_b_bits_id;
  logic [1:0]  io_b_bits_resp;

  logic        io_grant_ready;
  logic        io_grant_valid;
  logic [1:0]  io_grant_bits_header_src;
  logic [1:0]  io_grant_bits_header_dst;
  logic        io_grant_bits_client_xact_id;

  logic        io_err;

  modport master (
    output io_rel_ready,
    input  io_rel_valid, io_rel_bits_header_src, io_rel_bits_header_dst,
    input  io_rel_bits_payload_addr_beat, io_rel_bits_payload_addr_block,
    input  io_rel_bits_payload_client_xact_id, io_rel_bits_payload_voluntary,
    input  io_rel_bits_payload_r_type, io_rel_bits_payload_data,
    input  io_aw_ready,
    output io_aw_valid, io_aw_bits_addr, io_aw_bits_id, io_aw_bits_len, io_aw_bits_size,
    output io_aw_bits_burst,
    input  io_w_ready,
    output io_w_valid, io_w_bits_data, io_w_bits_strb, io_w_bits_last,
    output io_b_ready,
    input  io_b_valid, io_b_bits_id, io_b_bits_resp,
    input  io_grant_ready,
    output io_grant_valid, io_grant_bits_header_src, io_grant_bits_header_dst,
    output io_grant_bits_client_xact_id,
    output io_err
  );

  modport slave (
    input  io_rel_ready,
    output io_rel_valid, io_rel_bits_header_src, io_rel_bits_header_dst,
    output io_rel_bits_payload_addr_beat, io_rel_bits_payload_addr_block,
    output io_rel_bits_payload_client_xact_id, io_rel_bits_payload_voluntary,
    output io_rel_bits_payload_r_type, io_rel_bits_payload_data,
    output io_aw_ready,
    input  io_aw_valid, io_aw_bits_addr, io_aw_bits_id, io_aw_bits_len, io_aw_bits_size,
    input  io_aw_bits_burst,
    output io_w_ready,
    input  io_w_valid, io_w_bits_data, io_w_bits_strb, io_w_bits_last,
    input  io_b_ready,
    output io_b_valid, io_b_bits_id, io_b_bits_resp,
    output io_grant_ready,
    input  io_grant_valid, io_grant_bits_header_src, io_grant_bits_header_dst,
    input  io_grant_bits_client_xact_id,
    input  io_err
  );
endinterface

// File: rtl/release_axi_writer.sv
// Turns TileLink releases into AXI4 write bursts and answers voluntary releases with a grant
// once the write response has returned. One release is handled at a time.
module release_axi_writer #(
  parameter int unsigned DATA_BEATS = 8,
  parameter int unsigned BEAT_BYTES = 8
) (
  input logic                   clk,
  input logic                   reset,
  release_axi_writer_if.master  bus_io
);
  localparam int unsigned CntW = $clog2(DATA_BEATS);
  localparam logic [CntW-1:0] LastBeat = CntW'(DATA_BEATS - 1);

  typedef enum logic [2:0] {StIdle, StAw, StData, StResp, StGrant} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [1:0]      src_q, dst_q;
  logic            xact_q, vol_q, err_q;
  logic [25:0]     block_q;

  logic has_data, w_fire;

  assign has_data = (bus_io.io_rel_bits_payload_r_type == 3'd0) ||
                    (bus_io.io_rel_bits_payload_r_type == 3'd1);
  assign w_fire   = bus_io.io_w_valid && bus_io.io_w_ready;

  // DATA is a straight pass-through so beats are never buffered inside this block.
  always_comb begin
    bus_io.io_rel_ready = 1'b0;
    bus_io.io_w_valid   = 1'b0;
    case (state_q)
      StIdle:  bus_io.io_rel_ready = bus_io.io_rel_valid && !has_data;
      StData: begin
        bus_io.io_rel_ready = bus_io.io_w_ready;
        bus_io.io_w_valid   = bus_io.io_rel_valid;
      end
      default: ;
    endcase
  end

  assign bus_io.io_aw_valid      = (state_q == StAw);
  assign bus_io.io_aw_bits_addr  = {block_q, 6'd0};
  assign bus_io.io_aw_bits_id    = {src_q, xact_q};
  assign bus_io.io_aw_bits_len   = 8'(DATA_BEATS - 1);
  assign bus_io.io_aw_bits_size  = 3'($clog2(BEAT_BYTES));
  assign bus_io.io_aw_bits_burst = 2'b01;

  assign bus_io.io_w_bits_data = bus_io.io_rel_bits_payload_data;
  assign bus_io.io_w_bits_strb = '1;
  assign bus_io.io_w_bits_last = (cnt_q == LastBeat);

  assign bus_io.io_b_ready = (state_q == StResp);

  assign bus_io.io_grant_valid               = (state_q == StGrant);
  assign bus_io.io_grant_bits_header_src     = dst_q;
  assign bus_io.io_grant_bits_header_dst     = src_q;
  assign bus_io.io_grant_bits_client_xact_id = xact_q;

  assign bus_io.io_err = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      xact_q  <= 1'b0;
      vol_q   <= 1'b0;
      block_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus_io.io_rel_valid) begin
            src_q  <= bus_io.io_rel_bits_header_src;
            dst_q  <= bus_io.io_rel_bits_header_dst;
            xact_q <= bus_io.io_rel_bits_payload_client_xact_id;
            vol_q  <= bus_io.io_rel_bits_payload_voluntary;
            if (has_data) begin
              block_q <= bus_io.io_rel_bits_payload_addr_block;
              state_q <= StAw;
            end else if (bus_io.io_rel_bits_payload_voluntary) begin
              state_q <= StGrant;
            end
          end
        end
        StAw: begin
          if (bus_io.io_aw_ready) begin
            cnt_q   <= '0;
            state_q <= StData;
          end
        end
        StData: begin
          if (w_fire) begin
            // A misnumbered beat is still forwarded; it only raises the sticky flag.
            if (bus_io.io_rel_bits_payload_addr_beat != cnt_q) err_q <= 1'b1;
            if (cnt_q == LastBeat) begin
              cnt_q   <= '0;
              state_q <= StResp;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        StResp: begin
          if (bus_io.io_b_valid) begin
            if ((bus_io.io_b_bits_resp != 2'b00) || (bus_io.io_b_bits_id != {src_q, xact_q})) begin
              err_q <= 1'b1;
            end
            state_q <= vol_q ? StGrant : StIdle;
          end
        end
        StGrant: begin
          if (bus_io.io_grant_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end
endmodule

// File: tb/tb_release_axi_writer.sv
// Directed bench for release_axi_writer: a table of whole releases plus hand-written
// sequences for grant stall, W back-pressure, beat/response errors and mid-burst reset.
module tb_release_axi_writer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  release_axi_writer_if bus ();

  release_axi_writer #(.DATA_BEATS(8), .BEAT_BYTES(8)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus_io (bus)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] beat_data(input int tag, input int i);
    return {32'hC0DE_0000 + 32'(tag), 32'(i) * 32'h1111_1111};
  endfunction

  // Handshake monitor, sampled mid-cycle; counts are cumulative.
  int aw_n = 0, w_n = 0, b_n = 0, g_n = 0;
  logic [31:0] aw_addr_c;
  logic [2:0]  aw_id_c, aw_size_c;
  logic [7:0]  aw_len_c;
  logic [1:0]  aw_burst_c, g_src_c, g_dst_c;
  logic        g_xact_c;
  logic [63:0] w_data_c [512];
  logic        w_last_c [512];
  logic [7:0]  w_strb_c [512];
  bit          mirror_chk = 1'b0;
  bit          w_toggle = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.io_aw_valid && bus.io_aw_ready) begin
        aw_addr_c  = bus.io_aw_bits_addr;
        aw_id_c    = bus.io_aw_bits_id;
        aw_len_c   = bus.io_aw_bits_len;
        aw_size_c  = bus.io_aw_bits_size;
        aw_burst_c = bus.io_aw_bits_burst;
        aw_n++;
      end
      if (bus.io_w_valid && bus.io_w_ready) begin
        w_data_c[w_n % 512] = bus.io_w_bits_data;
        w_last_c[w_n % 512] = bus.io_w_bits_last;
        w_strb_c[w_n % 512] = bus.io_w_bits_strb;
        w_n++;
      end
      if (bus.io_b_valid && bus.io_b_ready) b_n++;
      if (bus.io_grant_valid && bus.io_grant_ready) begin
        g_src_c  = bus.io_grant_bits_header_src;
        g_dst_c  = bus.io_grant_bits_header_dst;
        g_xact_c = bus.io_grant_bits_client_xact_id;
        g_n++;
      end
      if (mirror_chk && bus.io_w_valid) begin
        chk("rel_ready_mirrors_w_ready", 64'(bus.io_rel_ready), 64'(bus.io_w_ready));
      end
    end
  end

  always @(posedge clk) begin
    if (w_toggle) begin
      #1 bus.io_w_ready = ~bus.io_w_ready;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Drives up to nsend beats of one release, each waiting (bounded) for acceptance.
  task automatic send(input logic [2:0] rtype, input logic vol, input logic [1:0] src,
                      input logic [1:0] dst, input logic xact, input logic [25:0] blk,
                      input logic [1:0] resp, input int tag, input int bad_beat,
                      input logic [2:0] bad_val, input int nsend);
    int nb;
    nb = (rtype <= 3'd1) ? 8 : 1;
    if (nsend < nb) nb = nsend;
    bus.io_rel_bits_header_src             = src;
    bus.io_rel_bits_header_dst             = dst;
    bus.io_rel_bits_payload_client_xact_id = xact;
    bus.io_rel_bits_payload_voluntary      = vol;
    bus.io_rel_bits_payload_r_type         = rtype;
    bus.io_rel_bits_payload_addr_block     = blk;
    bus.io_b_bits_id                       = {src, xact};
    bus.io_b_bits_resp                     = resp;
    for (int i = 0; i < nb; i++) begin
      int t;
      bus.io_rel_bits_payload_addr_beat = (i == bad_beat) ? bad_val : 3'(i);
      bus.io_rel_bits_payload_data      = beat_data(tag, i);
      bus.io_rel_valid                  = 1'b1;
      t = 0;
      @(negedge clk);
      while (!bus.io_rel_ready && t < 100) begin
        @(negedge clk);
        t++;
      end
      chk("rel_beat_accepted", 64'(bus.io_rel_ready), 64'd1);
      tick();
    end
    bus.io_rel_valid = 1'b0;
  endtask

  task automatic check_w(input int w0, input int tag, input int n);
    chk("w_beat_count", 64'(w_n - w0), 64'(n));
    for (int i = 0; i < n; i++) begin
      chk("w_data", w_data_c[(w0 + i) % 512], beat_data(tag, i));
      chk("w_last", 64'(w_last_c[(w0 + i) % 512]), 64'(i == 7));
      chk("w_strb", 64'(w_strb_c[(w0 + i) % 512]), 64'hFF);
    end
  endtask

  typedef struct {
    logic [2:0]  rtype;
    logic        vol;
    logic [1:0]  src;
    logic [1:0]  dst;
    logic        xact;
    logic [25:0] blk;
    logic [1:0]  resp;
    logic        exp_aw;
    logic [31:0] exp_addr;
    logic [2:0]  exp_id;
    logic        exp_grant;
    logic [1:0]  exp_gsrc;
    logic [1:0]  exp_gdst;
    logic        exp_gxact;
    logic        exp_err;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int aw0, w0, b0, g0;

    vecs[0] = '{3'd0, 1'b1, 2'd1, 2'd2, 1'b1, 26'h000_0123, 2'd0,
                1'b1, 32'h0000_48C0, 3'b011, 1'b1, 2'd2, 2'd1, 1'b1, 1'b0};
    vecs[1] = '{3'd2, 1'b0, 2'd0, 2'd1, 1'b0, 26'h000_0055, 2'd0,
                1'b0, 32'h0, 3'b000, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0};
    vecs[2] = '{3'd1, 1'b0, 2'd2, 2'd3, 1'b0, 26'h3FF_FFFF, 2'd0,
                1'b1, 32'hFFFF_FFC0, 3'b100, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0};
    vecs[3] = '{3'd3, 1'b1, 2'd3, 2'd0, 1'b1, 26'h000_0000, 2'd0,
                1'b0, 32'h0, 3'b000, 1'b1, 2'd0, 2'd3, 1'b1, 1'b0};
    vecs[4] = '{3'd7, 1'b0, 2'd1, 2'd1, 1'b0, 26'h123_4567, 2'd0,
                1'b0, 32'h0, 3'b000, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0};
    vecs[5] = '{3'd0, 1'b1, 2'd0, 2'd3, 1'b0, 26'h000_0001, 2'd2,
                1'b1, 32'h0000_0040, 3'b000, 1'b1, 2'd3, 2'd0, 1'b0, 1'b1};

    bus.io_rel_valid                       = 1'b0;
    bus.io_rel_bits_header_src             = '0;
    bus.io_rel_bits_header_dst             = '0;
    bus.io_rel_bits_payload_addr_beat      = '0;
    bus.io_rel_bits_payload_addr_block     = '0;
    bus.io_rel_bits_payload_client_xact_id = 1'b0;
    bus.io_rel_bits_payload_voluntary      = 1'b0;
    bus.io_rel_bits_payload_r_type         = '0;
    bus.io_rel_bits_payload_data           = '0;
    bus.io_aw_ready                        = 1'b1;
    bus.io_w_ready                         = 1'b1;
    bus.io_b_valid                         = 1'b1;
    bus.io_b_bits_id                       = '0;
    bus.io_b_bits_resp                     = '0;
    bus.io_grant_ready                     = 1'b1;

    apply_reset();
    @(negedge clk);
    chk("reset_aw_valid", 64'(bus.io_aw_valid), 64'd0);
    chk("reset_w_valid", 64'(bus.io_w_valid), 64'd0);
    chk("reset_b_ready", 64'(bus.io_b_ready), 64'd0);
    chk("reset_grant_valid", 64'(bus.io_grant_valid), 64'd0);
    chk("reset_rel_ready", 64'(bus.io_rel_ready), 64'd0);
    chk("reset_err", 64'(bus.io_err), 64'd0);
    tick();

    // Table of whole releases, all readies high.
    for (int k = 0; k < 6; k++) begin
      aw0 = aw_n; w0 = w_n; g0 = g_n; b0 = b_n;
      send(vecs[k].rtype, vecs[k].vol, vecs[k].src, vecs[k].dst, vecs[k].xact, vecs[k].blk,
           vecs[k].resp, k, -1, 3'd0, 8);
      repeat (6) tick();
      chk("aw_count", 64'(aw_n - aw0), 64'(vecs[k].exp_aw));
      chk("b_count", 64'(b_n - b0), 64'(vecs[k].exp_aw));
      if (vecs[k].exp_aw) begin
        chk("aw_addr", 64'(aw_addr_c), 64'(vecs[k].exp_addr));
        chk("aw_id", 64'(aw_id_c), 64'(vecs[k].exp_id));
        chk("aw_len", 64'(aw_len_c), 64'd7);
        chk("aw_size", 64'(aw_size_c), 64'd3);
        chk("aw_burst", 64'(aw_burst_c), 64'd1);
        check_w(w0, k, 8);
      end else begin
        chk("w_count_nodata", 64'(w_n - w0), 64'd0);
      end
      chk("grant_count", 64'(g_n - g0), 64'(vecs[k].exp_grant));
      if (vecs[k].exp_grant) begin
        chk("grant_src", 64'(g_src_c), 64'(vecs[k].exp_gsrc));
        chk("grant_dst", 64'(g_dst_c), 64'(vecs[k].exp_gdst));
        chk("grant_xact", 64'(g_xact_c), 64'(vecs[k].exp_gxact));
      end
      chk("err_after_txn", 64'(bus.io_err), 64'(vecs[k].exp_err));
    end

    // Beat 3 carries addr_beat=5: flag raised, burst still completes.
    apply_reset();
    chk("err_cleared_by_reset", 64'(bus.io_err), 64'd0);
    aw0 = aw_n; w0 = w_n; b0 = b_n;
    send(3'd0, 1'b0, 2'd2, 2'd1, 1'b1, 26'h00A_BCDE, 2'd0, 10, 3, 3'd5, 8);
    repeat (6) tick();
    chk("bad_beat_err", 64'(bus.io_err), 64'd1);
    chk("bad_beat_aw_count", 64'(aw_n - aw0), 64'd1);
    chk("bad_beat_b_count", 64'(b_n - b0), 64'd1);
    check_w(w0, 10, 8);

    // Reset after beat 4 of a burst abandons it; a fresh release then runs normally.
    send(3'd1, 1'b1, 2'd1, 2'd0, 1'b0, 26'h000_0777, 2'd0, 11, -1, 3'd0, 5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("midreset_aw_valid", 64'(bus.io_aw_valid), 64'd0);
    chk("midreset_w_valid", 64'(bus.io_w_valid), 64'd0);
    chk("midreset_b_ready", 64'(bus.io_b_ready), 64'd0);
    chk("midreset_grant_valid", 64'(bus.io_grant_valid), 64'd0);
    chk("midreset_rel_ready", 64'(bus.io_rel_ready), 64'd0);
    chk("midreset_err", 64'(bus.io_err), 64'd0);
    tick();
    aw0 = aw_n; w0 = w_n; g0 = g_n;
    send(3'd0, 1'b1, 2'd3, 2'd2, 1'b1, 26'h000_0002, 2'd0, 12, -1, 3'd0, 8);
    repeat (6) tick();
    chk("post_reset_aw_count", 64'(aw_n - aw0), 64'd1);
    chk("post_reset_aw_addr", 64'(aw_addr_c), 64'h80);
    chk("post_reset_aw_id", 64'(aw_id_c), 64'b111);
    check_w(w0, 12, 8);
    chk("post_reset_grant_count", 64'(g_n - g0), 64'd1);
    chk("post_reset_err", 64'(bus.io_err), 64'd0);

    // Voluntary non-data release with grant stalled 5 cycles, a new release waiting behind it.
    bus.io_grant_ready = 1'b0;
    aw0 = aw_n; g0 = g_n;
    send(3'd3, 1'b1, 2'd2, 2'd1, 1'b0, 26'h0, 2'd0, 13, -1, 3'd0, 1);
    bus.io_rel_bits_payload_r_type    = 3'd2;
    bus.io_rel_bits_payload_voluntary = 1'b0;
    bus.io_rel_valid                  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_grant_valid", 64'(bus.io_grant_valid), 64'd1);
      chk("stall_rel_ready", 64'(bus.io_rel_ready), 64'd0);
      tick();
    end
    bus.io_grant_ready = 1'b1;
    @(negedge clk);
    chk("stall_grant_cycle6", 64'(bus.io_grant_valid), 64'd1);
    tick();
    @(negedge clk);
    chk("after_grant_valid", 64'(bus.io_grant_valid), 64'd0);
    chk("after_grant_rel_ready", 64'(bus.io_rel_ready), 64'd1);
    tick();
    bus.io_rel_valid = 1'b0;
    chk("stall_grant_count", 64'(g_n - g0), 64'd1);
    chk("stall_grant_src", 64'(g_src_c), 64'd1);
    chk("stall_grant_dst", 64'(g_dst_c), 64'd2);
    chk("stall_aw_count", 64'(aw_n - aw0), 64'd0);

    // W ready toggling every cycle.
    aw0 = aw_n; w0 = w_n; b0 = b_n;
    w_toggle   = 1'b1;
    mirror_chk = 1'b1;
    send(3'd0, 1'b0, 2'd0, 2'd2, 1'b1, 26'h155_5555, 2'd0, 14, -1, 3'd0, 8);
    repeat (6) tick();
    w_toggle   = 1'b0;
    mirror_chk = 1'b0;
    tick();
    bus.io_w_ready = 1'b1;
    chk("bp_aw_count", 64'(aw_n - aw0), 64'd1);
    chk("bp_b_count", 64'(b_n - b0), 64'd1);
    check_w(w0, 14, 8);
    chk("bp_err", 64'(bus.io_err), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/release_axi_writer.md
Name: release_axi_writer

Overview:
- Consumes the dequeue side of the 2-entry release queue: TileLink release beats, each carrying a 2-bit header and a 64-bit payload.
- Converts data-carrying releases (8-beat writebacks) into AXI4 write bursts: AW, W and B channels.
- When a voluntary release's write response returns, it issues a voluntary-ack grant back toward the releasing client.
- Non-data releases are acknowledged without any AXI traffic.

Parameters:
- DATA_BEATS, 8, beats per cache block; also the AXI burst length minus one plus one (awlen = DATA_BEATS-1).
- BEAT_BYTES, 8, bytes per beat; awsize = log2(BEAT_BYTES) = 3.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- io_rel_ready  out  1  release beat accepted
- io_rel_valid  in  1  release beat present
- io_rel_bits_header_src  in  2  releasing client
- io_rel_bits_header_dst  in  2  manager id
- io_rel_bits_payload_addr_beat  in  3  beat index
- io_rel_bits_payload_addr_block  in  26  block address
- io_rel_bits_payload_client_xact_id  in  1  client transaction id
- io_rel_bits_payload_voluntary  in  1  voluntary writeback
- io_rel_bits_payload_r_type  in  3  release type
- io_rel_bits_payload_data  in  64  beat data
- io_aw_ready  in  1; io_aw_valid  out  1
- io_aw_bits_addr  out  32; io_aw_bits_id  out  3; io_aw_bits_len  out  8; io_aw_bits_size  out  3; io_aw_bits_burst  out  2
- io_w_ready  in  1; io_w_valid  out  1; io_w_bits_data  out  64; io_w_bits_strb  out  8; io_w_bits_last  out  1
- io_b_ready  out  1; io_b_valid  in  1; io_b_bits_id  in  3; io_b_bits_resp  in  2
- io_grant_ready  in  1; io_grant_valid  out  1
- io_grant_bits_header_src  out  2; io_grant_bits_header_dst  out  2; io_grant_bits_client_xact_id  out  1
- io_err  out  1  sticky protocol/response error

Behaviour:
- has_data = (r_type == 0) | (r_type == 1). All other r_type values carry no data.
- FSM states: IDLE, AW, DATA, RESP, GRANT.
- Reset: state=IDLE, beat counter=0, io_err=0. All valid/ready outputs are 0 in the cycle after reset.
- Reset mid-operation abandons any burst; the bench treats AXI state as discarded.

IDLE:
- Data release valid: latch src, dst, xact_id, voluntary, addr_block; go to AW. The beat is NOT consumed (io_rel_ready=0).
- Non-data release valid: io_rel_ready=1; consume in one cycle. If voluntary, latch header and go to GRANT; else stay in IDLE.

AW:
- io_aw_valid=1.
- addr = {addr_block, 6'b0}; id = {src, xact_id}; len = 7; size = 3; burst = 2'b01 (INCR).
- On aw handshake: go to DATA, beat counter = 0. AW must be accepted before any W beat is issued.

DATA:
- Combinational pass-through: io_w_valid = io_rel_valid; io_rel_ready = io_w_ready.
- w_data = payload data; strb = 8'hFF; w_last = (counter == 7).
- Each handshake increments the counter.
- addr_beat != counter on a handshake sets io_err; the beat is still forwarded.
- Handshake with counter == 7: go to RESP, counter wraps to 0.

RESP:
- io_b_ready = 1.
- On b handshake: resp != 0 or b_id != latched id sets io_err.
- Then go to GRANT if voluntary, else IDLE.

GRANT:
- io_grant_valid = 1; grant header src = latched dst, dst = latched src; xact_id = latched.
- On handshake: go to IDLE.

Concurrency and ordering:
- One release is in flight at a time. io_rel_ready = 0 in AW, RESP and GRANT, and in IDLE for data releases.
- A grant stalled by io_grant_ready=0 back-pressures all new releases.

io_err: set only by the conditions above; cleared only by reset.

Test Plan:
- Voluntary data release: block 0x0000123, src=1, xact=1, 8 beats, all readies high -> AW addr 0x000048C0, id=3'b011, len=7, size=3, burst=1. Then 8 W beats with last only on beat 7. After B OKAY: one grant with dst=1, src=latched dst, xact=1. io_err stays 0.
- Non-voluntary non-data release (r_type=2, voluntary=0) -> consumed in 1 cycle, no AW/W/grant activity, state back to IDLE.
- Voluntary non-data release (r_type=3) with io_grant_ready held low 5 cycles -> grant_valid held 5 cycles; io_rel_ready=0 throughout; grant completes on cycle 6.
- W back-pressure: io_w_ready toggles every cycle -> exactly 8 W handshakes, data matches release order, io_rel_ready mirrors io_w_ready.
- Error cases: beat 3 arrives with addr_beat=5 -> io_err=1 and burst still completes. Separately, B resp=2 on a fresh run -> io_err=1, grant still issued if voluntary.
- Reset asserted mid-DATA after beat 4 -> next cycle state IDLE, all valids 0, io_err=0; a new release proceeds normally.
